bcd_timekeeper: RTL and testbench
=================================

Name: bcd_timekeeper

Overview:
Parametrised next-generation BCD time-of-day register for the digital clock. Keeps hours, minutes and seconds internally in 24 h BCD and drives either 12 h or 24 h display digits. Adds a tick prescaler, a full-time parallel load with range checking, a day-of-week counter and a midnight rollover strobe. It sits between the 1 Hz (or faster) tick generator and the display/BCD-to-7-segment path.

Parameters:
TICK_DIV, 1, number of en pulses per one-second advance (1..255)
HAS_DAYS, 1, 1 = day-of-week counter present; 0 = day output tied to 0
NUM_DAYS, 7, day counter modulus (2..8)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  single-cycle tick strobe
military_time  in  1  1 = 24 h display, 0 = 12 h display
set_hours  in  1  increment hours this cycle
set_minutes  in  1  increment minutes this cycle
load  in  1  parallel-load strobe
load_time  in  24  {hh_msd,hh_lsd,mm_msd,mm_lsd,ss_msd,ss_lsd}, 24 h BCD
load_day  in  3  day value to load
load_err  out  1  one-cycle pulse: load rejected
rollover  out  1  one-cycle pulse: 23:59:59 -> 00:00:00
pm  out  1  12 h PM flag (0 in 24 h mode)
hours_msd  out  4  display hours tens
hours_lsd  out  4  display hours units
minutes_msd  out  4
minutes_lsd  out  4
seconds_msd  out  4
seconds_lsd  out  4
day  out  3  day-of-week 0..NUM_DAYS-1

Behaviour:
- Reset (async, rst_n=0): time 00:00:00, prescaler 0, day 0, load_err 0, rollover 0. Display outputs in 12 h mode then read 12:00:00, pm=0; in 24 h mode 00:00:00.
- State registers: 6 BCD digits (24 h), prescaler ceil(log2(TICK_DIV)) bits (none if TICK_DIV=1), day 3 bits, load_err, rollover. Display digits/pm combinational from state; military_time changes take effect immediately, never alter stored time.
- 12 h mapping: hh=00 -> 12, pm=0; 01..11 -> same, pm=0; 12 -> 12, pm=1; 13..23 -> hh-12, pm=1. Hours msd displayed as 0 (no blanking here).
- Priority per cycle: load > set_hours/set_minutes > en tick. Lower-priority actions in the same cycle are dropped (not deferred).
- Tick: on en=1, prescaler increments; when it equals TICK_DIV-1 it clears and seconds advance. Seconds 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours; hours 23 -> 00 asserts rollover for exactly one cycle (the cycle after the edge) and advances day (NUM_DAYS-1 -> 0). en ignored while rst_n=0.
- set_minutes: minutes +1 mod 60, no carry into hours; seconds and prescaler cleared.
- set_hours: hours +1 mod 24, no carry into day, no rollover pulse; seconds/minutes untouched.
- Both set inputs high: both increments applied in the same cycle, seconds/prescaler cleared.
- Set inputs are level: held high for N cycles gives N increments.
- load: accepted iff every digit <=9, ss<=59, mm<=59, hh<=23, and (HAS_DAYS=0 or load_day<NUM_DAYS). Accepted: time/day written, prescaler cleared, load_err=0. Rejected: state unchanged, load_err=1 for one cycle.
- HAS_DAYS=0: day=0 always, load_day ignored.
- Latency: every update visible on outputs immediately after the rising edge that performs it.

Test Plan:
- Reset mid-count at 13:27:45 with rst_n low -> outputs 12:00:00 pm=0 (12 h) asynchronously; prescaler restarts at 0.
- TICK_DIV=4, en every cycle from 00:00:00 -> seconds_lsd steps every 4th en; after 240 en pulses time = 00:01:00.
- Load 23:59:58 day 6, 2 ticks -> 00:00:00, rollover high one cycle, day=0; 12 h display 12:00:00 pm=0, 24 h 00:00:00.
- 12 h display sweep: load 00,11,12,13,23 hours -> displayed 12/AM, 11/AM, 12/PM, 01/PM, 11/PM.
- set_minutes held 7 cycles at 10:57:33 with en high -> 10:04:00, hours unchanged; set_hours 3 cycles at 22:xx -> 01:xx, no rollover, day unchanged.
- Load 24:00:00, 12:60:00, 0x1A digit, load_day=7 -> each rejected, load_err one-cycle pulse, time unchanged; load with set_hours and en simultaneous -> loaded value exactly.

Source files
------------

// File: rtl/bcd_timekeeper_if.sv
// Control, load and display signals between the tick/set logic and the BCD time-of-day register.
interface bcd_timekeeper_if;
    logic        en;
    logic        military_time;
    logic        set_hours;
    logic        set_minutes;
    logic        load;
    logic [23:0] load_time;
    logic [2:0]  load_day;
    logic        load_err;
    logic        rollover;
    logic        pm;
    logic [3:0]  hours_msd;
    logic [3:0]  hours_lsd;
    logic [3:0]  minutes_msd;
    logic [3:0]  minutes_lsd;
    logic [3:0]  seconds_msd;
    logic [3:0]  seconds_lsd;
    logic [2:0]  day;

    modport master (
        output en, military_time, set_hours, set_minutes, load, load_time, load_day,
        input  load_err, rollover, pm, hours_msd, hours_lsd, minutes_msd, minutes_lsd,
               seconds_msd, seconds_lsd, day
    );

    modport slave (
        input  en, military_time, set_hours, set_minutes, load, load_time, load_day,
        output load_err, rollover, pm, hours_msd, hours_lsd, minutes_msd, minutes_lsd,
               seconds_msd, seconds_lsd, day
    );
endinterface

// File: rtl/bcd_timekeeper.sv
// 24 h BCD time-of-day register with tick prescaler, checked parallel load, day counter, 12/24 h display.
// Latency: every update visible right after the performing clock edge; display mapping is combinational.
// No backpressure: strobes act in the cycle they are seen; lower-priority actions that cycle are dropped.
module bcd_timekeeper #(
    parameter int TICK_DIV = 1,
    parameter int HAS_DAYS = 1,
    parameter int NUM_DAYS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_timekeeper_if.slave  tk
);
    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]      DAY_MAX   = 3'(NUM_DAYS - 1);

    logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    day_q, day_d;
    logic          load_err_q, load_err_d;
    logic          rollover_q, rollover_d;

    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] inc_mod24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)          r = 8'h00;
        else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                     r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [3:0] ld_hm, ld_hl, ld_mm, ld_ml, ld_sm, ld_sl;
    logic       load_ok;
    assign {ld_hm, ld_hl, ld_mm, ld_ml, ld_sm, ld_sl} = tk.load_time;
    assign load_ok = (ld_hl <= 4'd9) && (ld_ml <= 4'd9) && (ld_sl <= 4'd9)
                  && (ld_mm <= 4'd5) && (ld_sm <= 4'd5)
                  && ((ld_hm < 4'd2) || ((ld_hm == 4'd2) && (ld_hl <= 4'd3)))
                  && ((HAS_DAYS == 0) || ({1'b0, tk.load_day} < 4'(NUM_DAYS)));

    always_comb begin
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        presc_d    = presc_q;
        day_d      = day_q;
        load_err_d = 1'b0;
        rollover_d = 1'b0;
        if (tk.load) begin
            if (load_ok) begin
                hh_d    = tk.load_time[23:16];
                mm_d    = tk.load_time[15:8];
                ss_d    = tk.load_time[7:0];
                presc_d = '0;
                day_d   = (HAS_DAYS != 0) ? tk.load_day : 3'd0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tk.set_hours || tk.set_minutes) begin
            // Manual sets never carry into the next field
            if (tk.set_minutes) begin
                mm_d    = inc_mod60(mm_q);
                ss_d    = 8'h00;
                presc_d = '0;
            end
            if (tk.set_hours) hh_d = inc_mod24(hh_q);
        end else if (tk.en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                ss_d    = inc_mod60(ss_q);
                if (ss_q == 8'h59) begin
                    mm_d = inc_mod60(mm_q);
                    if (mm_q == 8'h59) begin
                        hh_d = inc_mod24(hh_q);
                        if (hh_q == 8'h23) begin
                            rollover_d = 1'b1;
                            if (HAS_DAYS != 0) day_d = (day_q == DAY_MAX) ? 3'd0 : day_q + 3'd1;
                        end
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hh_q       <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            day_q      <= 3'd0;
            load_err_q <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            day_q      <= day_d;
            load_err_q <= load_err_d;
            rollover_q <= rollover_d;
        end
    end

    // A divide-by-one tick needs no prescaler state; the constant zero always matches PRESC_MAX
    if (TICK_DIV > 1) begin : g_presc
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) presc_q <= '0;
            else        presc_q <= presc_d;
        end
    end else begin : g_no_presc
        logic unused_presc;
        assign presc_q      = '0;
        assign unused_presc = ^presc_d;
    end

    logic [4:0] hr_bin, hr12;
    logic       pm_c;
    logic [3:0] disp_msd, disp_lsd;
    assign hr_bin = 5'(hh_q[7:4]) * 5'd10 + 5'(hh_q[3:0]);

    always_comb begin
        hr12     = hr_bin;
        pm_c     = 1'b0;
        disp_msd = hh_q[7:4];
        disp_lsd = hh_q[3:0];
        if (!tk.military_time) begin
            if (hr_bin == 5'd0) begin
                hr12 = 5'd12;
            end else if (hr_bin >= 5'd12) begin
                pm_c = 1'b1;
                if (hr_bin > 5'd12) hr12 = hr_bin - 5'd12;
            end
            if (hr12 >= 5'd10) begin
                disp_msd = 4'd1;
                disp_lsd = 4'(hr12 - 5'd10);
            end else begin
                disp_msd = 4'd0;
                disp_lsd = 4'(hr12);
            end
        end
    end

    assign tk.hours_msd   = disp_msd;
    assign tk.hours_lsd   = disp_lsd;
    assign tk.pm          = pm_c;
    assign tk.minutes_msd = mm_q[7:4];
    assign tk.minutes_lsd = mm_q[3:0];
    assign tk.seconds_msd = ss_q[7:4];
    assign tk.seconds_lsd = ss_q[3:0];
    assign tk.day         = day_q;
    assign tk.load_err    = load_err_q;
    assign tk.rollover    = rollover_q;
endmodule

// File: tb/tb_bcd_timekeeper.sv
// Bench for bcd_timekeeper: directed scenarios and random traffic against a seconds-of-day reference model.
module tb_bcd_timekeeper;
    localparam int TD = 4;
    localparam int ND = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_timekeeper_if bus();

    bcd_timekeeper #(.TICK_DIV(TD), .HAS_DAYS(1), .NUM_DAYS(ND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tk    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: time as seconds since midnight
    int m_sec, m_pre, m_day;
    bit m_err, m_roll;

    wire logic [29:0] obs = {bus.load_err, bus.rollover, bus.pm,
                             bus.hours_msd, bus.hours_lsd, bus.minutes_msd, bus.minutes_lsd,
                             bus.seconds_msd, bus.seconds_lsd, bus.day};

    function automatic logic [23:0] bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [29:0] model_outs(input bit mil);
        int hh, mm, ss, h;
        bit p;
        hh = m_sec / 3600;
        mm = (m_sec / 60) % 60;
        ss = m_sec % 60;
        h  = hh;
        p  = 1'b0;
        if (!mil) begin
            if (hh == 0)       h = 12;
            else if (hh == 12) p = 1'b1;
            else if (hh > 12)  begin h = hh - 12; p = 1'b1; end
        end
        return {m_err, m_roll, p, bcd(h, mm, ss), 3'(m_day)};
    endfunction

    task automatic model_reset();
        m_sec = 0; m_pre = 0; m_day = 0; m_err = 0; m_roll = 0;
    endtask

    task automatic model_update(input bit e, input bit sh, input bit sm, input bit ld,
                                input logic [23:0] lt, input logic [2:0] lday);
        int hh, mm, ss;
        int d[6];
        bit ok;
        if (!rst_n) return;
        m_err = 0;
        m_roll = 0;
        hh = m_sec / 3600;
        mm = (m_sec / 60) % 60;
        ss = m_sec % 60;
        if (ld) begin
            ok = 1;
            for (int i = 0; i < 6; i++) begin
                d[i] = int'(lt[4*i +: 4]);
                if (d[i] > 9) ok = 0;
            end
            if (d[5] * 10 + d[4] > 23) ok = 0;
            if (d[3] * 10 + d[2] > 59) ok = 0;
            if (d[1] * 10 + d[0] > 59) ok = 0;
            if (int'(lday) >= ND) ok = 0;
            if (ok) begin
                m_sec = (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
                m_pre = 0;
                m_day = int'(lday);
            end else begin
                m_err = 1;
            end
        end else if (sh || sm) begin
            if (sm) begin mm = (mm + 1) % 60; ss = 0; m_pre = 0; end
            if (sh) hh = (hh + 1) % 24;
            m_sec = hh * 3600 + mm * 60 + ss;
        end else if (e) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                m_sec++;
                if (m_sec == 86400) begin
                    m_sec = 0;
                    m_roll = 1;
                    m_day = (m_day + 1) % ND;
                end
            end else begin
                m_pre++;
            end
        end
    endtask

    // Drive one cycle's inputs, clock them in, update the model, then settle past the edge
    task automatic step(input bit e, input bit sh, input bit sm, input bit ld,
                        input logic [23:0] lt, input logic [2:0] lday);
        bus.en = e; bus.set_hours = sh; bus.set_minutes = sm;
        bus.load = ld; bus.load_time = lt; bus.load_day = lday;
        @(posedge clk);
        model_update(e, sh, sm, ld, lt, lday);
        #1;
    endtask

    task automatic test_reset();
        logic [29:0] exp12;
        exp12 = {3'b000, bcd(12, 0, 0), 3'd0};
        bus.military_time = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp12) begin errors++; $display("FAIL reset_initial got=%h exp=%h", obs, exp12); end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 1, bcd(13, 27, 45), 3'd2);
        step(1, 0, 0, 0, 24'h0, 3'd0);
        step(1, 0, 0, 0, 24'h0, 3'd0);
        checks++;
        if (obs !== model_outs(0)) begin errors++; $display("FAIL reset_precount got=%h exp=%h", obs, model_outs(0)); end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp12) begin errors++; $display("FAIL reset_async got=%h exp=%h", obs, exp12); end
        step(1, 0, 0, 0, 24'h0, 3'd0);
        checks++;
        if (obs !== exp12) begin errors++; $display("FAIL reset_en_ignored got=%h exp=%h", obs, exp12); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 1; k <= TD; k++) begin
            step(1, 0, 0, 0, 24'h0, 3'd0);
            checks++;
            if (obs !== model_outs(0)) begin errors++; $display("FAIL reset_presc_restart en=%0d got=%h exp=%h", k, obs, model_outs(0)); end
        end
        checks++;
        if (bus.seconds_lsd !== 4'd1) begin errors++; $display("FAIL reset_first_second got=%0d exp=1", bus.seconds_lsd); end
    endtask

    task automatic test_prescaler();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        bus.military_time = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            step(1, 0, 0, 0, 24'h0, 3'd0);
            checks++;
            if (obs !== model_outs(1)) begin errors++; $display("FAIL presc_step en=%0d got=%h exp=%h", k, obs, model_outs(1)); end
        end
        checks++;
        if (obs[26:3] !== bcd(0, 1, 0)) begin errors++; $display("FAIL presc_240 got=%h exp=%h", obs[26:3], bcd(0, 1, 0)); end
    endtask

    task automatic test_rollover();
        bus.military_time = 1'b0;
        step(0, 0, 0, 1, bcd(23, 59, 58), 3'd6);
        for (int k = 1; k <= 2 * TD; k++) begin
            step(1, 0, 0, 0, 24'h0, 3'd0);
            checks++;
            if (obs !== model_outs(0)) begin errors++; $display("FAIL roll_step en=%0d got=%h exp=%h", k, obs, model_outs(0)); end
        end
        checks++;
        if (obs !== {3'b010, bcd(12, 0, 0), 3'd0}) begin errors++; $display("FAIL roll_12h got=%h exp=%h", obs, {3'b010, bcd(12, 0, 0), 3'd0}); end
        bus.military_time = 1'b1;
        #1;
        checks++;
        if (obs !== {3'b010, bcd(0, 0, 0), 3'd0}) begin errors++; $display("FAIL roll_24h got=%h exp=%h", obs, {3'b010, bcd(0, 0, 0), 3'd0}); end
        step(0, 0, 0, 0, 24'h0, 3'd0);
        checks++;
        if (bus.rollover !== 1'b0) begin errors++; $display("FAIL roll_one_cycle got=%b exp=0", bus.rollover); end
    endtask

    task automatic test_12h_sweep();
        int hrs[5]   = '{0, 11, 12, 13, 23};
        int shown[5] = '{12, 11, 12, 1, 11};
        bit pms[5]   = '{0, 0, 1, 1, 1};
        logic [8:0] got, exp;
        bus.military_time = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, bcd(hrs[i], 34, 56), 3'd1);
            got = {bus.pm, bus.hours_msd, bus.hours_lsd};
            exp = {pms[i], 4'(shown[i] / 10), 4'(shown[i] % 10)};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL sweep_h%0d got=%h exp=%h", hrs[i], got, exp); end
            checks++;
            if (obs !== model_outs(0)) begin errors++; $display("FAIL sweep_model_h%0d got=%h exp=%h", hrs[i], obs, model_outs(0)); end
        end
    endtask

    task automatic test_set();
        bus.military_time = 1'b1;
        step(0, 0, 0, 1, bcd(10, 57, 33), 3'd4);
        for (int k = 1; k <= 7; k++) begin
            step(1, 0, 1, 0, 24'h0, 3'd0);
            checks++;
            if (obs !== model_outs(1)) begin errors++; $display("FAIL setmin_step %0d got=%h exp=%h", k, obs, model_outs(1)); end
        end
        checks++;
        if (obs !== {3'b000, bcd(10, 4, 0), 3'd4}) begin errors++; $display("FAIL setmin_final got=%h exp=%h", obs, {3'b000, bcd(10, 4, 0), 3'd4}); end
        step(0, 0, 0, 1, bcd(22, 15, 20), 3'd3);
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 0, 0, 24'h0, 3'd0);
            checks++;
            if (obs !== model_outs(1)) begin errors++; $display("FAIL sethr_step %0d got=%h exp=%h", k, obs, model_outs(1)); end
        end
        checks++;
        if (obs !== {3'b000, bcd(1, 15, 20), 3'd3}) begin errors++; $display("FAIL sethr_final got=%h exp=%h", obs, {3'b000, bcd(1, 15, 20), 3'd3}); end
    endtask

    task automatic test_load_err();
        logic [23:0] bad_t[4] = '{24'h240000, 24'h126000, 24'h1A0000, 24'h010203};
        logic [2:0]  bad_d[4] = '{3'd1, 3'd1, 3'd1, 3'd7};
        bus.military_time = 1'b1;
        step(0, 0, 0, 1, bcd(5, 6, 7), 3'd5);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, bad_t[i], bad_d[i]);
            checks++;
            if (obs !== {3'b100, bcd(5, 6, 7), 3'd5}) begin errors++; $display("FAIL loaderr_%0d got=%h exp=%h", i, obs, {3'b100, bcd(5, 6, 7), 3'd5}); end
            step(0, 0, 0, 0, 24'h0, 3'd0);
            checks++;
            if (obs !== model_outs(1)) begin errors++; $display("FAIL loaderr_clear_%0d got=%h exp=%h", i, obs, model_outs(1)); end
        end
        step(1, 1, 0, 1, bcd(8, 9, 10), 3'd2);
        checks++;
        if (obs !== {3'b000, bcd(8, 9, 10), 3'd2}) begin errors++; $display("FAIL load_priority got=%h exp=%h", obs, {3'b000, bcd(8, 9, 10), 3'd2}); end
    endtask

    task automatic test_random();
        bit e, sh, sm, ld;
        logic [23:0] lt;
        logic [2:0] lday;
        for (int k = 0; k < 3000; k++) begin
            bus.military_time = 1'($urandom_range(0, 1));
            e  = ($urandom_range(0, 3) != 0);
            sh = ($urandom_range(0, 19) == 0);
            sm = ($urandom_range(0, 19) == 0);
            ld = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1) == 1)
                lt = bcd($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            else
                lt = 24'($urandom);
            if ($urandom_range(0, 3) == 0) lt = bcd(23, 59, $urandom_range(50, 59));
            lday = 3'($urandom_range(0, 7));
            step(e, sh, sm, ld, lt, lday);
            checks++;
            if (obs !== model_outs(bus.military_time)) begin
                errors++;
                $display("FAIL random_%0d got=%h exp=%h", k, obs, model_outs(bus.military_time));
            end
        end
    endtask

    initial begin
        bus.en = 0; bus.set_hours = 0; bus.set_minutes = 0; bus.load = 0;
        bus.load_time = '0; bus.load_day = '0; bus.military_time = 0;
        test_reset();
        test_prescaler();
        test_rollover();
        test_12h_sweep();
        test_set();
        test_load_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
